keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_debounce.sv | 32 +++
 rtl/keypad_entry.sv | 176 +++++++++++++++++
 tb/tb_keypad_entry.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, FSM states, BCD width.
package keypad_pkg;

   localparam int unsigned BCD_W = 4;

   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_LOAD  = 4'hF;
   localparam logic [3:0] KEY_BKSP  = 4'hB;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // Index of the lowest set bit; also the index of a one-hot vector.
   function automatic logic [1:0] low_idx(input logic [3:0] v);
      if (v[0])      low_idx = 2'd0;
      else if (v[1]) low_idx = 2'd1;
      else if (v[2]) low_idx = 2'd2;
      else           low_idx = 2'd3;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-cycle counter: clears on clr_i, counts while en_i, flags the CNT-th stable cycle.
module keypad_debounce #(
   parameter int unsigned CNT = 40000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic done_c
);

   localparam int unsigned CW = (CNT > 1) ? $clog2(CNT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // done_c is true during the cycle that completes CNT stable cycles.
   assign done_c = (cnt_q == CW'(CNT - 1));

   // Next count: clear has priority over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + CW'(1);
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and 4-digit BCD (MM:SS) entry.
// Optional: define KEYPAD_ENTRY_BACKSPACE_EN to make key 0xB shift digits right.
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 2000,
   parameter int unsigned DEBOUNCE_CNT = 40000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [15:0] digits,
   output logic        load,
   output logic        err
);

   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [3:0]    row_s1_q, row_s2_q;
   state_t        state_q, state_d;
   logic [3:0]    col_q, col_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [3:0]    row_cap_q, row_cap_d;
   logic          key_valid_q, key_valid_d;
   logic [3:0]    key_code_q, key_code_d;
   logic [15:0]   digits_q, digits_d;
   logic          load_q, load_d;
   logic          err_q, err_d;
   logic          db_clr, db_en, db_done;
   logic          any_row, row_same;

   assign any_row  = |row_s2_q;
   assign row_same = (row_s2_q == row_cap_q);

   keypad_debounce #(.CNT(DEBOUNCE_CNT)) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (db_clr),
      .en_i   (db_en),
      .done_c (db_done)
   );

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1_q <= '0;
         row_s2_q <= '0;
      end else begin
         row_s1_q <= row;
         row_s2_q <= row_s1_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_SCAN;
      else     state_q <= state_d;
   end

   // Next state and debounce counter control.
   always_comb begin
      state_d = state_q;
      db_clr  = 1'b1;
      db_en   = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (any_row) state_d = ST_DEBOUNCE;
         end
         ST_DEBOUNCE: begin
            if (!row_same) begin
               state_d = ST_SCAN;
            end else begin
               db_clr = 1'b0;
               db_en  = 1'b1;
               if (db_done) state_d = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (!any_row) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (any_row) begin
               state_d = ST_PRESSED;
            end else begin
               db_clr = 1'b0;
               db_en  = 1'b1;
               if (db_done) state_d = ST_SCAN;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   // FSM outputs: column rotation, row capture and the accepted-key pulse.
   always_comb begin
      col_d       = col_q;
      scan_cnt_d  = '0;
      row_cap_d   = row_cap_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      case (state_q)
         ST_SCAN: begin
            if (any_row) begin
               row_cap_d = row_s2_q;
            end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
               col_d = {col_q[2:0], col_q[3]};
            end else begin
               scan_cnt_d = scan_cnt_q + SW'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (row_same && db_done) begin
               key_valid_d = 1'b1;
               key_code_d  = {low_idx(row_cap_q), low_idx(col_q)};
            end
         end
         default: ;
      endcase
   end

   // Digit entry acting on the key accepted in the previous cycle.
   always_comb begin
      digits_d = digits_q;
      load_d   = 1'b0;
      err_d    = 1'b0;
      if (key_valid_q) begin
         if (key_code_q <= 4'd9) begin
            digits_d = {digits_q[3*BCD_W-1:0], key_code_q};
         end else if (key_code_q == KEY_CLEAR) begin
            digits_d = '0;
         end else if (key_code_q == KEY_LOAD) begin
            if (digits_q[2*BCD_W-1:BCD_W] <= 4'd5) load_d = 1'b1;
            else                                  err_d  = 1'b1;
         end
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
         else if (key_code_q == KEY_BKSP) begin
            digits_d = {4'h0, digits_q[4*BCD_W-1:BCD_W]};
         end
`endif
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q       <= 4'b0001;
         scan_cnt_q  <= '0;
         row_cap_q   <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         digits_q    <= '0;
         load_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         col_q       <= col_d;
         scan_cnt_q  <= scan_cnt_d;
         row_cap_q   <= row_cap_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         digits_q    <= digits_d;
         load_q      <= load_d;
         err_q       <= err_d;
      end
   end

   assign col       = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign digits    = digits_q;
   assign load      = load_q;
   assign err       = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a column-gated keypad model.
module tb_keypad_entry;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DEB      = 8;
   localparam int          HOLD     = 24;
   localparam int          REL      = 24;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] digits;
   logic        load;
   logic        err;

   logic        key_on = 1'b0;
   logic [1:0]  key_r  = 2'd0;
   logic [1:0]  key_c  = 2'd0;

   int errors = 0;
   int checks = 0;
   int kv_cnt = 0;
   int load_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   logic [3:0] last_code = 4'h0;

   int kv_base, ld_base, er_base;
   logic [15:0] exp_bk;

   keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code),
      .digits    (digits),
      .load      (load),
      .err       (err)
   );

   always #5 clk = ~clk;

   // A key closes its row only while its column is driven.
   assign row = (key_on && col[key_c]) ? (4'b0001 << key_r) : 4'b0000;

   // Pulse monitors sampled on the inactive edge.
   always @(negedge clk) begin
      if (key_valid) begin
         kv_cnt    <= kv_cnt + 1;
         last_code <= key_code;
      end
      if (load) load_cnt <= load_cnt + 1;
      if (err)  err_cnt  <= err_cnt + 1;
      if (load && err) both_cnt <= both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Wait until the column for c freshly becomes driven.
   task automatic wait_col(input logic [1:0] c);
      logic [3:0] tgt;
      logic [3:0] prev;
      tgt  = 4'b0001 << c;
      prev = col;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (col == tgt && prev != tgt) break;
         prev = col;
      end
      chk("wait_col", 32'(col), 32'(tgt));
   endtask

   task automatic press_key(input logic [3:0] code);
      key_r = code[3:2];
      key_c = code[1:0];
      wait_col(code[1:0]);
      key_on = 1'b1;
      repeat (HOLD) @(negedge clk);
      key_on = 1'b0;
      repeat (REL) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_col",    32'(col),       32'h1);
      chk("rst_kv",     32'(key_valid), 32'h0);
      chk("rst_code",   32'(key_code),  32'h0);
      chk("rst_digits", 32'(digits),    32'h0);
      chk("rst_load",   32'(load),      32'h0);
      chk("rst_err",    32'(err),       32'h0);
      rst = 1'b0;

      // Long hold of key 6: one pulse, column frozen until release completes.
      kv_base = kv_cnt;
      key_r = 2'd1; key_c = 2'd2;
      wait_col(2'd2);
      key_on = 1'b1;
      repeat (2 * DEB) @(negedge clk);
      chk("hold_col",  32'(col), 32'h4);
      chk("hold_kv",   32'(kv_cnt - kv_base), 32'd1);
      repeat (2 * DEB) @(negedge clk);
      chk("hold_once", 32'(kv_cnt - kv_base), 32'd1);
      key_on = 1'b0;
      repeat (4) @(negedge clk);
      chk("rel_col",   32'(col), 32'h4);
      for (int i = 0; i < 60 && col == 4'b0100; i++) @(negedge clk);
      chk("rel_scan",  32'(col != 4'b0100), 32'h1);
      chk("k6_code",   32'(last_code), 32'h6);
      chk("k6_digits", 32'(digits), 32'h0006);

      // Bounce shorter than the debounce window: no pulse, scanning resumes.
      kv_base = kv_cnt;
      key_r = 2'd0; key_c = 2'd0;
      wait_col(2'd0);
      key_on = 1'b1;
      repeat (DEB / 2) @(negedge clk);
      key_on = 1'b0;
      repeat (40) @(negedge clk);
      chk("bounce_kv", 32'(kv_cnt - kv_base), 32'd0);
      for (int i = 0; i < 40 && col == 4'b0001; i++) @(negedge clk);
      chk("bounce_scan", 32'(col != 4'b0001), 32'h1);

      // Shift entry: oldest digit falls off.
      kv_base = kv_cnt;
      press_key(4'h1); press_key(4'h2); press_key(4'h3);
      press_key(4'h4); press_key(4'h5);
      chk("seq_kv",     32'(kv_cnt - kv_base), 32'd5);
      chk("seq_digits", 32'(digits), 32'h2345);

      // Load rejected when tens > 5, accepted when tens == 5.
      press_key(4'hC); press_key(4'h1); press_key(4'h2);
      press_key(4'h6); press_key(4'h0);
      chk("d1260", 32'(digits), 32'h1260);
      ld_base = load_cnt; er_base = err_cnt;
      press_key(4'hF);
      chk("bad_err",    32'(err_cnt - er_base),  32'd1);
      chk("bad_load",   32'(load_cnt - ld_base), 32'd0);
      chk("bad_digits", 32'(digits), 32'h1260);
      press_key(4'hC); press_key(4'h5); press_key(4'h9);
      chk("d0059", 32'(digits), 32'h0059);
      ld_base = load_cnt; er_base = err_cnt;
      press_key(4'hF);
      chk("ok_load",   32'(load_cnt - ld_base), 32'd1);
      chk("ok_err",    32'(err_cnt - er_base),  32'd0);
      chk("ok_digits", 32'(digits), 32'h0059);

      // Backspace key, then an unused code.
      press_key(4'hC); press_key(4'h1); press_key(4'h2);
      press_key(4'h3); press_key(4'h4);
      chk("d1234", 32'(digits), 32'h1234);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
      exp_bk = 16'h0123;
`else
      exp_bk = 16'h1234;
`endif
      press_key(4'hB);
      chk("bksp", 32'(digits), 32'(exp_bk));
      press_key(4'hA);
      chk("unused_digits", 32'(digits), 32'(exp_bk));
      chk("code_held",     32'(key_code), 32'hA);

      // Reset in mid-debounce suppresses the pending pulse.
      kv_base = kv_cnt;
      key_r = 2'd1; key_c = 2'd1;
      wait_col(2'd1);
      key_on = 1'b1;
      repeat (6) @(negedge clk);
      chk("db_frozen", 32'(col), 32'h2);
      rst = 1'b1;
      #1;
      chk("mid_col",    32'(col),       32'h1);
      chk("mid_kv",     32'(key_valid), 32'h0);
      chk("mid_code",   32'(key_code),  32'h0);
      chk("mid_digits", 32'(digits),    32'h0);
      chk("mid_load",   32'(load),      32'h0);
      chk("mid_err",    32'(err),       32'h0);
      key_on = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("mid_nokv", 32'(kv_cnt - kv_base), 32'd0);

      // Key held across reset counts as a fresh press afterwards.
      kv_base = kv_cnt;
      key_r = 2'd1; key_c = 2'd3;
      wait_col(2'd3);
      key_on = 1'b1;
      for (int i = 0; i < 60 && kv_cnt == kv_base; i++) @(negedge clk);
      chk("held_first", 32'(kv_cnt - kv_base), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("held_again",  32'(kv_cnt - kv_base), 32'd2);
      chk("held_code",   32'(last_code), 32'h7);
      key_on = 1'b0;
      repeat (REL) @(negedge clk);
      chk("held_digits", 32'(digits), 32'h0007);

      chk("load_err_excl", 32'(both_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
